// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcode/phase definitions for the RISC sequencing controller
// Contents:
//   OPCODE_W, PHASE_W : fixed field widths (3 bits each)
//   opcode_e          : instruction opcodes HLT..JMP
//   phase_e           : the eight instruction phases
//   ALUOP_SET         : membership mask of opcodes that read an operand into the accumulator
//   is_aluop()        : membership test against ALUOP_SET
package risc_pkg;

  localparam int OPCODE_W = 3;
  localparam int PHASE_W  = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [PHASE_W-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  // Bit n set means opcode n is an ALU-class opcode (ADD, AND, XOR, LDA).
  localparam logic [7:0] ALUOP_SET = 8'b0011_1100;

  function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
    return ALUOP_SET[op];
  endfunction

endpackage

// File: rtl/risc_controller_counter.sv
// rtl/risc_controller_counter.sv - loadable up-counter used as the phase generator
// Parameters:
//   COUNTER_WIDTH : counter width in bits
// Ports:
//   clk    in  : clock, counts on rising edge
//   rst    in  : asynchronous active-low reset, clears count
//   load   in  : synchronous load of data (has priority over enable)
//   enable in  : count enable
//   data   in  : load value
//   count  out : current count, wraps at 2**COUNTER_WIDTH
module risc_controller_counter #(
  parameter int COUNTER_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     enable,
  input  logic [COUNTER_WIDTH-1:0] data,
  output logic [COUNTER_WIDTH-1:0] count
);

  logic [COUNTER_WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= data;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/risc_controller.sv
// rtl/risc_controller.sv - eight-phase instruction sequencer and control decode
// Configuration macro: RISC_CTRL_HALT_LATCH_EN
//   defined   : HLT freezes the phase at 4 and holds halt high until reset
//   undefined : halt is a single-phase pulse in phase 4, sequencing continues
// Ports:
//   clk    in  : system clock
//   rst    in  : asynchronous active-low reset
//   opcode in  : current instruction opcode (3 bits)
//   zero   in  : accumulator-is-zero flag
//   phase  out : current phase 0..7
//   sel    out : address mux select (1 = PC, 0 = IR operand)
//   rd     out : memory read strobe
//   ld_ir  out : instruction register load
//   inc_pc out : program counter increment enable
//   ld_pc  out : program counter load
//   ld_ac  out : accumulator load
//   wr     out : memory write strobe
//   data_e out : data bus drive enable for store
//   halt   out : halt indication
module risc_controller
  import risc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic [PHASE_W-1:0]  phase,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                ld_ac,
  output logic                wr,
  output logic                data_e,
  output logic                halt
);

  logic [PHASE_W-1:0] w_count;
  logic               w_hold;
  logic               w_alu;
  logic               w_skz;
  logic               w_sto;
  logic               w_jmp;
  logic               w_hlt;

  assign w_alu = is_aluop(opcode);
  assign w_skz = (opcode == OP_SKZ);
  assign w_sto = (opcode == OP_STO);
  assign w_jmp = (opcode == OP_JMP);
  assign w_hlt = (opcode == OP_HLT);

`ifdef RISC_CTRL_HALT_LATCH_EN
  logic r_halted;
  logic w_halt_entry;

  assign w_halt_entry = (phase_e'(w_count) == PH_OP_ADDR) && w_hlt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_halted <= 1'b0;
    end else if (w_halt_entry) begin
      r_halted <= 1'b1;
    end
  end

  // The entry term is included so the counter does not step past phase 4
  // on the very edge that latches the halted state.
  assign w_hold = r_halted | w_halt_entry;
`else
  assign w_hold = 1'b0;
`endif

  risc_controller_counter #(
    .COUNTER_WIDTH(PHASE_W)
  ) u_phase_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b0),
    .enable (~w_hold),
    .data   ({PHASE_W{1'b0}}),
    .count  (w_count)
  );

  assign phase = w_count;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    case (phase_e'(w_count))
      PH_INST_ADDR: begin
        sel = 1'b1;
      end
      PH_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      PH_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = w_hlt;
      end
      PH_OP_FETCH: begin
        rd = w_alu;
      end
      PH_ALU_OP: begin
        rd     = w_alu;
        ld_pc  = w_jmp;
        // JMP dominates so the PC never sees load and increment together.
        inc_pc = w_skz & zero & ~w_jmp;
        data_e = w_sto;
      end
      PH_STORE: begin
        rd     = w_alu;
        ld_ac  = w_alu;
        ld_pc  = w_jmp;
        wr     = w_sto;
        data_e = w_sto;
      end
      default: begin
      end
    endcase
`ifdef RISC_CTRL_HALT_LATCH_EN
    if (r_halted) begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_risc_controller.sv
// tb/tb_risc_controller.sv - directed self-checking bench for risc_controller
module tb_risc_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

  int n_tests;
  int n_fail;

  risc_controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-opcode expected activity: bit p of each mask is the signal value in phase p.
  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [7:0] rd_m;
    logic [7:0] inc_m;
    logic [7:0] ldpc_m;
    logic [7:0] ldac_m;
    logic [7:0] wr_m;
    logic [7:0] de_m;
    logic [7:0] hlt_m;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
  function automatic logic [11:0] outs();
    return {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
  endfunction

  task automatic run_instr(input vec_t v);
    logic [7:0] m_sel, m_rd, m_ldir, m_inc, m_ldpc, m_ldac, m_wr, m_de, m_hlt;
    m_sel = '0; m_rd = '0; m_ldir = '0; m_inc = '0; m_ldpc = '0;
    m_ldac = '0; m_wr = '0; m_de = '0; m_hlt = '0;
    rst    = 1'b0;
    opcode = v.op;
    zero   = v.z;
    step();
    rst = 1'b1;
    #1;
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("op%0d_z%0d_phase_seq%0d", v.op, v.z, p), {29'd0, phase}, p);
      m_sel[p]  = sel;
      m_rd[p]   = rd;
      m_ldir[p] = ld_ir;
      m_inc[p]  = inc_pc;
      m_ldpc[p] = ld_pc;
      m_ldac[p] = ld_ac;
      m_wr[p]   = wr;
      m_de[p]   = data_e;
      m_hlt[p]  = halt;
      chk($sformatf("op%0d_p%0d_pc_excl", v.op, p), {31'd0, inc_pc & ld_pc}, 32'd0);
      step();
    end
    chk($sformatf("op%0d_wrap", v.op), {29'd0, phase}, 32'd0);
    chk($sformatf("op%0d_sel", v.op),    {24'd0, m_sel},  32'h0F);
    chk($sformatf("op%0d_ld_ir", v.op),  {24'd0, m_ldir}, 32'h0C);
    chk($sformatf("op%0d_rd", v.op),     {24'd0, m_rd},   {24'd0, v.rd_m});
    chk($sformatf("op%0d_inc_pc", v.op), {24'd0, m_inc},  {24'd0, v.inc_m});
    chk($sformatf("op%0d_ld_pc", v.op),  {24'd0, m_ldpc}, {24'd0, v.ldpc_m});
    chk($sformatf("op%0d_ld_ac", v.op),  {24'd0, m_ldac}, {24'd0, v.ldac_m});
    chk($sformatf("op%0d_wr", v.op),     {24'd0, m_wr},   {24'd0, v.wr_m});
    chk($sformatf("op%0d_data_e", v.op), {24'd0, m_de},   {24'd0, v.de_m});
    chk($sformatf("op%0d_halt", v.op),   {24'd0, m_hlt},  {24'd0, v.hlt_m});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    opcode  = 3'd5;
    zero    = 1'b0;

    // Reset state: phase 0, only sel high.
    #3;
    chk("reset_state", {20'd0, outs()}, {20'd0, 12'b000_1_0000_0000});

    //            op    z     rd            inc           ldpc          ldac          wr            de            halt
    vq.push_back('{3'd5, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000}); // LDA
    vq.push_back('{3'd2, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000}); // ADD
    vq.push_back('{3'd4, 1'b1, 8'b1110_1110, 8'b0001_0000, 8'b0000_0000, 8'b1000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000}); // XOR
    vq.push_back('{3'd1, 1'b1, 8'b0000_1110, 8'b0101_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000}); // SKZ z=1
    vq.push_back('{3'd1, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000}); // SKZ z=0
    vq.push_back('{3'd7, 1'b1, 8'b0000_1110, 8'b0001_0000, 8'b1100_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000}); // JMP
    vq.push_back('{3'd6, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'b0000_0000, 8'b0000_0000, 8'b1000_0000, 8'b1100_0000, 8'b0000_0000}); // STO
`ifndef RISC_CTRL_HALT_LATCH_EN
    vq.push_back('{3'd0, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0001_0000}); // HLT pulse
`endif

    foreach (vq[i]) run_instr(vq[i]);

`ifdef RISC_CTRL_HALT_LATCH_EN
    // HLT latches: phase frozen at 4, only halt high, until reset.
    rst = 1'b0; opcode = 3'd0; zero = 1'b0;
    step();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) step();
    chk("hlt_enter_phase4", {20'd0, outs()}, {20'd0, 12'b100_0_0010_0001});
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("hlt_hold%0d", i), {20'd0, outs()}, {20'd0, 12'b100_0_0000_0001});
    end
    opcode = 3'd5;
    step();
    chk("hlt_sticky_opchange", {20'd0, outs()}, {20'd0, 12'b100_0_0000_0001});
    rst = 1'b0;
    #1;
    chk("hlt_reset_clear", {20'd0, outs()}, {20'd0, 12'b000_1_0000_0000});
    step();
    rst = 1'b1;
    step();
    chk("hlt_after_reset_phase1", {29'd0, phase}, 32'd1);
`endif

    // Asynchronous reset during phase 6 of ADD aborts before ld_ac.
    rst = 1'b0; opcode = 3'd2; zero = 1'b0;
    step();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) step();
    chk("abort_phase6", {20'd0, outs()}, {20'd0, 12'b110_0_1000_0000});
    #2;
    rst = 1'b0;
    #1;
    chk("abort_async_outputs", {20'd0, outs()}, {20'd0, 12'b000_1_0000_0000});
    step();
    chk("abort_held_no_ld_ac", {20'd0, outs()}, {20'd0, 12'b000_1_0000_0000});
    rst = 1'b1;
    step();
    chk("abort_first_edge_phase1", {29'd0, phase}, 32'd1);
    chk("abort_first_edge_ld_ac", {31'd0, ld_ac}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_controller.md
RISC_CONTROLLER -- requirements
Module: risc_controller

Interface
REQ-001 Parameters: none; opcode width 3 and phase width 3 are fixed constants from the shared package.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  3  current instruction opcode from instruction register; sampled combinationally.
REQ-005 zero  input  1  accumulator-is-zero flag.
REQ-006 phase  output  3  current instruction phase, 0..7.
REQ-007 sel  output  1  memory address mux select: 1 = PC, 0 = IR operand.
REQ-008 rd  output  1  memory read strobe.
REQ-009 ld_ir  output  1  instruction register load.
REQ-010 inc_pc  output  1  program counter increment enable, drives Counter enable.
REQ-011 ld_pc  output  1  program counter load, drives Counter load.
REQ-012 ld_ac  output  1  accumulator load.
REQ-013 wr  output  1  memory write strobe.
REQ-014 data_e  output  1  data bus tristate enable for store.
REQ-015 halt  output  1  processor halt indication.

Function
REQ-016 Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7; ALUOP = ADD|AND|XOR|LDA.
REQ-017 Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-018 phase SHALL advance by 1 each clk rising edge and wrap 7 -> 0, except as REQ-026/REQ-033 state.
REQ-019 Control outputs SHALL be combinational decode of registered phase, opcode and zero (zero-cycle latency within phase).
REQ-020 sel = 1 in phases 0-3, else 0.
REQ-021 rd = 1 in phases 1-3; rd = ALUOP in phases 5-7; else 0.
REQ-022 ld_ir = 1 in phases 2-3; inc_pc = 1 in phase 4; inc_pc = (SKZ & zero) in phase 6.
REQ-023 ld_ac = ALUOP in phase 7; ld_pc = JMP in phases 6-7; wr = STO in phase 7; data_e = STO in phases 6-7.
REQ-024 halt = HLT in phase 4.
REQ-025 ld_pc and inc_pc SHALL never both be 1 in the same cycle; JMP dominates.
REQ-026 Halted state: entered on the clk edge ending phase 4 with opcode HLT; all outputs except halt = 0, phase frozen at 4.

Reset
REQ-027 rst low SHALL immediately force phase = 0, clear the halted state, and drive every output to its phase-0 value (sel = 1, all others 0).
REQ-028 Reset asserted mid-instruction SHALL abort it; the first rising edge after rst deasserts moves phase to 1.

Configuration
REQ-029 Macro RISC_CTRL_HALT_LATCH_EN.
REQ-030 Defined: REQ-026 applies; halt stays 1 until reset.
REQ-031 Undefined: no halted state; halt is a one-phase pulse in phase 4 and sequencing continues to phase 5 (external logic gates clk).

Structure
REQ-032 Shared package risc_pkg holds the opcode enum, phase enum and ALUOP membership constant.
REQ-033 The phase generator SHALL instantiate the existing Counter sub-module with COUNTER_WIDTH = 3, load tied 0, enable = not halted.

Verification
REQ-034 Reset release with opcode=LDA -> phase 0..7 in order; rd = 1 in phases 1-3 and 5-7; ld_ac = 1 only in phase 7.
REQ-035 opcode=SKZ, zero=1 -> inc_pc = 1 in phases 4 and 6; zero=0 -> inc_pc = 1 in phase 4 only.
REQ-036 opcode=JMP -> ld_pc = 1 in phases 6-7, inc_pc = 0 there, wr = 0 throughout.
REQ-037 opcode=STO -> data_e = 1 in phases 6-7, wr = 1 in phase 7 only, rd = 0 in phases 5-7.
REQ-038 opcode=HLT with macro defined -> halt = 1, phase stays 4 for 10 cycles; rst low -> phase = 0, halt = 0. Without macro -> halt pulses once, phase reaches 5.
REQ-039 rst pulsed low asynchronously during phase 6 of ADD -> outputs reach phase-0 values before next clk edge; ld_ac never asserted.
